// File: rtl/dds_wavegen_pkg.sv
// Shared definitions for the DDS waveform generator: waveform encodings and
// default widths.
package dds_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    localparam int DW_DEF = 8;
    localparam int PW_DEF = 16;
    localparam int LW_DEF = 8;

endpackage

// File: rtl/dds_wavegen_if.sv
// Control and sample-stream bundle between a DDS controller and the generator.
interface dds_wavegen_if
    import dds_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF
);
    logic          en;
    logic          sync;
    logic [PW-1:0] fcw;
    logic [PW-1:0] phase_off;
    logic [1:0]    wave_sel;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          wrap;

    modport master (
        output en, sync, fcw, phase_off, wave_sel,
        input  dout, dout_valid, wrap
    );

    modport slave (
        input  en, sync, fcw, phase_off, wave_sel,
        output dout, dout_valid, wrap
    );
endinterface

// File: rtl/dds_wavegen_sine_quarter_rom.sv
// Quarter-wave sine magnitude table, entries round((2^(DW-1)-1)*sin(pi/2*k/N)).
// Purely combinational; the parent registers the read.
module sine_quarter_rom #(
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic [LW-3:0] addr_i,
    output logic [DW-2:0] data_o
);
    localparam int  N       = 2 ** (LW - 2);
    localparam real AMP     = real'(2 ** (DW - 1) - 1);
    localparam real HALF_PI = 1.57079632679489661923;

    logic [DW-2:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_entry
        localparam int V = $rtoi(AMP * $sin(HALF_PI * real'(k) / real'(N)) + 0.5);
        assign rom[k] = (DW-1)'(V);
    end

    assign data_o = rom[addr_i];
endmodule

// File: rtl/dds_wavegen.sv
// Three-stage DDS generator: phase accumulator with period-boundary shadow
// registers, phase/address register, and registered waveform synthesis.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    dds_wavegen_if.slave  bus
);
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    // Stage 0
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] fcw_act_q, fcw_act_d;
    wave_e         sel_act_q, sel_act_d;
    logic          carry_q, carry_d;
    logic          v0_q, v0_d;
    logic [PW:0]   sum;

    // Stage 1
    logic [LW-1:0] addr;
    logic [1:0]    quad_q;
    logic [LW-3:0] idx_q;
    logic [DW-1:0] top_q;
    wave_e         sel1_q;
    logic          v1_q, c1_q;

    // Stage 2
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, wrap_q;
    logic [LW-3:0] rom_addr;
    logic [DW-2:0] rom_data;
    logic [DW-1:0] tri_w;

    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, fcw_act_q};
        acc_d     = acc_q;
        carry_d   = 1'b0;
        v0_d      = bus.en & ~bus.sync;
        fcw_act_d = fcw_act_q;
        sel_act_d = sel_act_q;
        if (bus.sync) begin
            acc_d = '0;
        end else if (bus.en) begin
            acc_d   = sum[PW-1:0];
            carry_d = sum[PW];
        end
        // Shadows only follow the inputs when no period is in progress.
        if (!bus.en || bus.sync || sum[PW]) begin
            fcw_act_d = bus.fcw;
            sel_act_d = wave_e'(bus.wave_sel);
        end
    end

    assign addr = LW'((acc_q + bus.phase_off) >> (PW - LW));

    // Odd quadrants read the table mirrored.
    assign rom_addr = quad_q[0] ? ~idx_q : idx_q;
    assign tri_w    = {top_q[DW-2:0], 1'b0};

    sine_quarter_rom #(.DW(DW), .LW(LW)) u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        dout_d = MID;
        case (sel1_q)
            WAVE_SINE:   dout_d = quad_q[1] ? (MID - {1'b0, rom_data})
                                            : (MID + {1'b0, rom_data});
            WAVE_SQUARE: dout_d = top_q[DW-1] ? '0 : '1;
            WAVE_TRI:    dout_d = top_q[DW-1] ? ~tri_w : tri_w;
            WAVE_SAW:    dout_d = top_q;
            default:     dout_d = MID;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            fcw_act_q <= '0;
            sel_act_q <= WAVE_SINE;
            carry_q   <= 1'b0;
            v0_q      <= 1'b0;
            quad_q    <= '0;
            idx_q     <= '0;
            top_q     <= '0;
            sel1_q    <= WAVE_SINE;
            v1_q      <= 1'b0;
            c1_q      <= 1'b0;
            dout_q    <= MID;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            fcw_act_q <= fcw_act_d;
            sel_act_q <= sel_act_d;
            carry_q   <= carry_d;
            v0_q      <= v0_d;
            quad_q    <= addr[LW-1:LW-2];
            idx_q     <= addr[LW-3:0];
            top_q     <= DW'((acc_q + bus.phase_off) >> (PW - DW));
            sel1_q    <= sel_act_q;
            v1_q      <= v0_q;
            c1_q      <= carry_q;
            dout_q    <= dout_d;
            valid_q   <= v1_q;
            wrap_q    <= c1_q;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.wrap       = wrap_q;
endmodule
